// File: rtl/mac_sequencer.sv
// MAC datapath sequencer: walks ROM addresses per row pair, captures results.
// Optional abort input when MAC_SEQ_ABORT_EN is defined.
module mac_sequencer #(
    parameter int ADDR_WIDTH   = 6,
    parameter int RESULT_WIDTH = 24,
    parameter int K_STEPS      = 4,
    parameter int NUM_PAIRS    = 2,
    parameter int PIPE_LAT     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   romA_addrA,
    output logic [ADDR_WIDTH-1:0]   romA_addrB,
    output logic [ADDR_WIDTH-1:0]   romB_addrA,
    output logic [ADDR_WIDTH-1:0]   romB_addrB,
    output logic [ADDR_WIDTH-1:0]   romC_addrA,
    output logic [ADDR_WIDTH-1:0]   romC_addrB,
    output logic                    clear,
    output logic                    enable_mult,
    output logic                    enable_sum,
    input  logic [RESULT_WIDTH-1:0] finalResultA,
    input  logic [RESULT_WIDTH-1:0] finalResultB,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_index,
    output logic [RESULT_WIDTH-1:0] out_resultA,
    output logic [RESULT_WIDTH-1:0] out_resultB
);

    if (2 * NUM_PAIRS * K_STEPS > 2 ** ADDR_WIDTH) begin : g_cfg_err
        $error("mac_sequencer: address space too small");
    end

    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MULT, S_DRAIN,
        S_SUM, S_CAPTURE, S_DONE, S_ABORT
    } state_t;

    state_t state_q, state_n;

    logic [ADDR_WIDTH-1:0] p_q, p_n;
    logic [ADDR_WIDTH-1:0] k_q, k_n;
    logic [CW-1:0]         cnt_q, cnt_n;

    logic accept;
    logic last_pair;
    logic capture;
    logic abort_req;

    logic                    busy_n, done_n;
    logic                    clear_n, mult_n, sum_n;
    logic                    valid_n;
    logic [ADDR_WIDTH-1:0]   index_n;
    logic [RESULT_WIDTH-1:0] resa_n, resb_n;
    logic [ADDR_WIDTH-1:0]   aa_n, ab_n, ba_n, bb_n, ca_n, cb_n;
    logic [31:0]             row_e, row_c;

    assign accept    = out_valid & out_ready;
    assign last_pair = (p_q == ADDR_WIDTH'(NUM_PAIRS - 1));
    assign capture   = (state_q == S_CAPTURE) &&
                       (cnt_q == CW'(PIPE_LAT - 1)) &&
                       (state_n != S_ABORT);

`ifdef MAC_SEQ_ABORT_EN
    assign abort_req = abort & (state_q != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            clear       <= 1'b0;
            enable_mult <= 1'b0;
            enable_sum  <= 1'b0;
            romA_addrA  <= '0;
            romA_addrB  <= '0;
            romB_addrA  <= '0;
            romB_addrB  <= '0;
            romC_addrA  <= '0;
            romC_addrB  <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_resultA <= '0;
            out_resultB <= '0;
        end else begin
            state_q     <= state_n;
            p_q         <= p_n;
            k_q         <= k_n;
            cnt_q       <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            clear       <= clear_n;
            enable_mult <= mult_n;
            enable_sum  <= sum_n;
            romA_addrA  <= aa_n;
            romA_addrB  <= ab_n;
            romB_addrA  <= ba_n;
            romB_addrB  <= bb_n;
            romC_addrA  <= ca_n;
            romC_addrB  <= cb_n;
            out_valid   <= valid_n;
            out_index   <= index_n;
            out_resultA <= resa_n;
            out_resultB <= resb_n;
        end
    end

    always_comb begin
        state_n = state_q;
        p_n     = p_q;
        k_n     = k_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                p_n   = '0;
                k_n   = '0;
                cnt_n = '0;
                if (start) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                k_n     = '0;
                state_n = S_MULT;
            end
            S_MULT: begin
                if (k_q == ADDR_WIDTH'(K_STEPS - 1)) begin
                    k_n     = '0;
                    cnt_n   = '0;
                    state_n = S_DRAIN;
                end else begin
                    k_n = k_q + 1'b1;
                end
            end
            // Minimum drain lets the last product land; also parks here
            // while the previous result is still unaccepted.
            S_DRAIN: begin
                if (cnt_q < CW'(PIPE_LAT)) begin
                    cnt_n = cnt_q + 1'b1;
                end else if (!out_valid || out_ready) begin
                    state_n = S_SUM;
                end
            end
            S_SUM: begin
                cnt_n   = '0;
                state_n = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (cnt_q == CW'(PIPE_LAT - 1)) begin
                    cnt_n = '0;
                    if (last_pair) begin
                        state_n = S_DONE;
                    end else begin
                        p_n     = p_q + 1'b1;
                        state_n = S_CLEAR;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (accept) state_n = S_IDLE;
            end
            S_ABORT: begin
                p_n     = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort_req) begin
            p_n     = '0;
            k_n     = '0;
            cnt_n   = '0;
            state_n = S_ABORT;
        end
    end

    always_comb begin
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_q == S_DONE) && (state_n == S_IDLE);
        clear_n = (state_n == S_CLEAR) || (state_n == S_ABORT);
        mult_n  = (state_n == S_MULT);
        sum_n   = (state_n == S_SUM);

        row_e = 32'(p_n) * 32'(2 * K_STEPS) + 32'(k_n);
        row_c = 32'(p_n) * 32'd2;
        aa_n  = ADDR_WIDTH'(row_e);
        ab_n  = ADDR_WIDTH'(row_e + 32'(K_STEPS));
        ba_n  = k_n;
        bb_n  = k_n;
        ca_n  = ADDR_WIDTH'(row_c);
        cb_n  = ADDR_WIDTH'(row_c + 32'd1);

        valid_n = out_valid;
        index_n = out_index;
        resa_n  = out_resultA;
        resb_n  = out_resultB;
        if (capture) begin
            valid_n = 1'b1;
            index_n = p_q;
            resa_n  = finalResultA;
            resb_n  = finalResultB;
        end else if (accept) begin
            valid_n = 1'b0;
        end
        if (state_n == S_ABORT) valid_n = 1'b0;
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with ROM and MAC models plus a scoreboard.
// Define MAC_SEQ_ABORT_EN to also exercise the abort path.
module tb_mac_sequencer;

    localparam int AW = 6;
    localparam int RW = 24;
    localparam int K  = 4;
    localparam int NP = 2;
    localparam int PL = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic          busy, done;
    logic [AW-1:0] romA_addrA, romA_addrB;
    logic [AW-1:0] romB_addrA, romB_addrB;
    logic [AW-1:0] romC_addrA, romC_addrB;
    logic          clear, enable_mult, enable_sum;
    wire  [RW-1:0] finalResultA, finalResultB;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_index;
    logic [RW-1:0] out_resultA, out_resultB;

    mac_sequencer #(
        .ADDR_WIDTH(AW), .RESULT_WIDTH(RW), .K_STEPS(K),
        .NUM_PAIRS(NP), .PIPE_LAT(PL)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
`ifdef MAC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done),
        .romA_addrA(romA_addrA), .romA_addrB(romA_addrB),
        .romB_addrA(romB_addrA), .romB_addrB(romB_addrB),
        .romC_addrA(romC_addrA), .romC_addrB(romC_addrB),
        .clear(clear), .enable_mult(enable_mult), .enable_sum(enable_sum),
        .finalResultA(finalResultA), .finalResultB(finalResultB),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index),
        .out_resultA(out_resultA), .out_resultB(out_resultB)
    );

    always #5 clock = ~clock;

    logic [31:0] romA_mem [64];
    logic [31:0] romB_mem [64];
    logic [15:0] romC_mem [64];

    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s = 0;
        for (int i = 0; i < 4; i++) s += 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
        return s;
    endfunction

    function automatic logic [RW-1:0] golden(input int row);
        logic [31:0] s = 0;
        for (int k = 0; k < K; k++) s += dot(romA_mem[row*K + k], romB_mem[k]);
        s += 32'(romC_mem[row]);
        return RW'(s);
    endfunction

    // MAC model: products land PL cycles after enable_mult, sum bus PL after enable_sum
    logic        mv0 = 0, mv1 = 0, sv0 = 0, sv1 = 0;
    logic [31:0] pa0 = 0, pa1 = 0, pb0 = 0, pb1 = 0;
    logic [31:0] accA = 0, accB = 0;

    always @(posedge clock) begin
        mv0 <= enable_mult;
        mv1 <= mv0;
        pa0 <= dot(romA_mem[romA_addrA], romB_mem[romB_addrA]);
        pb0 <= dot(romA_mem[romA_addrB], romB_mem[romB_addrB]);
        pa1 <= pa0;
        pb1 <= pb0;
        if (clear) begin
            accA <= 0;
            accB <= 0;
        end else if (mv1) begin
            accA <= accA + pa1;
            accB <= accB + pb1;
        end
        sv0 <= enable_sum;
        sv1 <= sv0;
    end

    assign finalResultA = sv1 ? RW'(accA + 32'(romC_mem[romC_addrA])) : 'z;
    assign finalResultB = sv1 ? RW'(accB + 32'(romC_mem[romC_addrB])) : 'z;

    typedef struct {
        logic [AW-1:0] idx;
        logic [RW-1:0] a;
        logic [RW-1:0] b;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] log_a[$];
    logic [AW-1:0] log_b[$];
    int            checks   = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [RW-1:0] last_a   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (enable_mult) begin
                log_a.push_back(romA_addrA);
                log_b.push_back(romA_addrB);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_index", 32'(out_index), 32'(e.idx));
                    chk("sb_resA", 32'(out_resultA), 32'(e.a));
                    chk("sb_resB", 32'(out_resultB), 32'(e.b));
                    last_a = out_resultA;
                end
            end
        end
    end

    task automatic push_pair(input int p);
        exp_t e;
        e.idx = AW'(p);
        e.a   = golden(2*p);
        e.b   = golden(2*p + 1);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(done), 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            romA_mem[i] = $urandom;
            romB_mem[i] = $urandom;
            romC_mem[i] = 16'($urandom);
        end
    endtask

    initial begin
        int n;
        logic [RW-1:0] snap;
        fill_rand();

        // reset with start held high
        start = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_ctl", {busy, done, clear, enable_mult, enable_sum, out_valid}, 0);
        chk("rst_addr", {romA_addrA, romA_addrB, romB_addrA, romB_addrB}, 0);
        chk("rst_addrc", {romC_addrA, romC_addrB, out_index}, 0);
        chk("rst_res", {out_resultA, out_resultB}, 0);
        repeat (3) @(negedge clock);
        chk("idle_busy", {busy, clear, enable_mult}, 0);

        // nominal run, random ROMs
        log_a.delete();
        log_b.delete();
        done_cnt = 0;
        for (int p = 0; p < NP; p++) push_pair(p);
        pulse_start();
        chk("busy_run", 32'(busy), 1);
        wait_done("run1_done");
        chk("run1_busy", 32'(busy), 0);
        chk("run1_done_cnt", done_cnt, 1);
        chk("run1_sb_empty", exp_q.size(), 0);
        chk("run1_loglen", log_a.size(), 2*K);
        for (int j = 0; j < log_a.size(); j++) begin
            chk("addrA_seq", 32'(log_a[j]), (j/K)*2*K + j%K);
            chk("addrB_seq", 32'(log_b[j]), (j/K)*2*K + K + j%K);
        end

        // all-ones ROMs: widest result
        for (int i = 0; i < 64; i++) begin
            romA_mem[i] = 32'hFFFF_FFFF;
            romB_mem[i] = 32'hFFFF_FFFF;
            romC_mem[i] = 16'hFFFF;
        end
        for (int p = 0; p < NP; p++) push_pair(p);
        pulse_start();
        wait_done("ff_done");
        chk("ff_resA", 32'(last_a), 16*32'hFE01 + 32'hFFFF);
        chk("ff_sb_empty", exp_q.size(), 0);

        // backpressure after first capture
        fill_rand();
        out_ready = 1'b0;
        for (int p = 0; p < NP; p++) push_pair(p);
        pulse_start();
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("bp_valid", 32'(out_valid), 1);
        snap = out_resultA;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            chk("bp_ctl", {out_valid, clear, enable_mult, enable_sum}, 4'b1000);
            chk("bp_stable", 32'(out_resultA), 32'(snap));
            @(negedge clock);
        end
        out_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_sb_empty", exp_q.size(), 0);

        // reset during MULT of pair 1
        done_cnt = 0;
        push_pair(0);
        pulse_start();
        n = 0;
        while (!(enable_mult && romC_addrA == AW'(2)) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("rs_in_mult", 32'(enable_mult), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rs_after", {enable_mult, out_valid, busy, done}, 0);
        chk("rs_sb_empty", exp_q.size(), 0);
        repeat (4) @(negedge clock);
        chk("rs_idle", {busy, clear, enable_mult}, 0);
        chk("rs_no_done", done_cnt, 0);
        for (int p = 0; p < NP; p++) push_pair(p);
        pulse_start();
        wait_done("rs_rerun_done");
        chk("rs_rerun_sb", exp_q.size(), 0);

`ifdef MAC_SEQ_ABORT_EN
        done_cnt = 0;
        pulse_start();
        n = 0;
        while (!enable_sum && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("ab_in_sum", 32'(enable_sum), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("ab_clear", {clear, enable_sum, enable_mult, out_valid}, 4'b1000);
        @(negedge clock);
        chk("ab_idle", {busy, clear, out_valid}, 0);
        repeat (20) @(negedge clock);
        chk("ab_no_done", done_cnt, 0);
        chk("ab_sb", exp_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
